// File: rtl/gray_count_tx.sv
// Source-domain binary/Gray counter feeding a multi-flop synchronizer.
// All outputs are registered; GRAY_OUT is encoded from the next binary value.
module gray_count_tx #(
    parameter int unsigned bus_width = 4,
    parameter bit          SAT_MODE  = 1'b0
) (
    input  logic                 CLK_source_count,
    input  logic                 RST_counter,
    input  logic                 EN,
    input  logic                 CLR,
    input  logic                 DIR,
    output logic [bus_width-1:0] BIN_OUT,
    output logic [bus_width-1:0] GRAY_OUT,
    output logic                 TOG,
    output logic                 WRAP
);

    logic [bus_width-1:0] bin_q, bin_d;
    logic [bus_width-1:0] gray_q, gray_d;
    logic                 tog_q, tog_d;
    logic                 wrap_q, wrap_d;
    logic                 at_bound;

    always_comb begin
        bin_d    = bin_q;
        tog_d    = tog_q;
        wrap_d   = 1'b0;
        at_bound = DIR ? (bin_q == {bus_width{1'b1}}) : (bin_q == '0);
        if (CLR) begin
            bin_d = '0;
        end else if (EN) begin
            // In saturating mode a step past the bound is not a step at all.
            if (!(at_bound && SAT_MODE)) begin
                bin_d  = DIR ? bin_q + 1'b1 : bin_q - 1'b1;
                tog_d  = ~tog_q;
                wrap_d = at_bound;
            end
        end
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge CLK_source_count or negedge RST_counter) begin
        if (!RST_counter) begin
            bin_q  <= '0;
            gray_q <= '0;
            tog_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            tog_q  <= tog_d;
            wrap_q <= wrap_d;
        end
    end

    assign BIN_OUT  = bin_q;
    assign GRAY_OUT = gray_q;
    assign TOG      = tog_q;
    assign WRAP     = wrap_q;

endmodule

// File: tb/tb_gray_count_tx.sv
// Bench for gray_count_tx: wrapping and saturating instances against an
// integer reference model, directed sequences, random traffic and a 3-flop sync.
module tb_gray_count_tx;

    localparam int W   = 4;
    localparam int Max = (1 << W) - 1;

    logic clk = 1'b0;
    logic dclk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic clr = 1'b0;
    logic dir = 1'b1;

    logic [W-1:0] bin0, gray0, bin1, gray1;
    logic         tog0, wrap0, tog1, wrap1;

    gray_count_tx #(.bus_width(W), .SAT_MODE(1'b0)) dut_wrap (
        .CLK_source_count(clk),
        .RST_counter     (rst_n),
        .EN              (en),
        .CLR             (clr),
        .DIR             (dir),
        .BIN_OUT         (bin0),
        .GRAY_OUT        (gray0),
        .TOG             (tog0),
        .WRAP            (wrap0)
    );

    gray_count_tx #(.bus_width(W), .SAT_MODE(1'b1)) dut_sat (
        .CLK_source_count(clk),
        .RST_counter     (rst_n),
        .EN              (en),
        .CLR             (clr),
        .DIR             (dir),
        .BIN_OUT         (bin1),
        .GRAY_OUT        (gray1),
        .TOG             (tog1),
        .WRAP            (wrap1)
    );

    // Source posedges at 10 mod 20; destination posedges at 5 mod 8 never coincide.
    initial forever #10 clk = ~clk;
    initial begin
        #5;
        forever begin
            dclk = 1'b1;
            #4;
            dclk = 1'b0;
            #4;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: index 0 wraps, index 1 saturates.
    int cnt [2];
    bit mtog [2];
    bit mwrap [2];
    int hist [$];
    int quiet = 0;
    bit last_clr = 1'b1;

    function automatic int to_gray(input int v);
        return v ^ (v >> 1);
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            cnt[m] = 0;
            mtog[m] = 1'b0;
            mwrap[m] = 1'b0;
        end
    endtask

    task automatic model_step(input int m);
        bit at_b;
        if (clr) begin
            cnt[m] = 0;
            mwrap[m] = 1'b0;
        end else if (en) begin
            at_b = dir ? (cnt[m] == Max) : (cnt[m] == 0);
            if (at_b && m == 1) begin
                mwrap[m] = 1'b0;
            end else begin
                cnt[m] = dir ? (cnt[m] + 1) % (Max + 1) : (cnt[m] + Max) % (Max + 1);
                mtog[m] = ~mtog[m];
                mwrap[m] = at_b;
            end
        end else begin
            mwrap[m] = 1'b0;
        end
    endtask

    task automatic tick();
        logic [W-1:0] prev_gray;
        prev_gray = gray0;
        @(posedge clk);
        if (rst_n) begin
            model_step(0);
            model_step(1);
        end
        #1;
        check_val("bin0", bin0, cnt[0]);
        check_val("gray0", gray0, to_gray(cnt[0]));
        check_val("tog0", tog0, mtog[0]);
        check_val("wrap0", wrap0, mwrap[0]);
        check_val("bin1", bin1, cnt[1]);
        check_val("gray1", gray1, to_gray(cnt[1]));
        check_val("tog1", tog1, mtog[1]);
        check_val("wrap1", wrap1, mwrap[1]);
        if (!last_clr && !clr && rst_n)
            check_val("hamming", ($countones(prev_gray ^ gray0) <= 1), 1);
        last_clr = clr || !rst_n;
        hist.push_back(to_gray(cnt[0]));
        if (hist.size() > 4) void'(hist.pop_front());
        quiet = (clr || !rst_n) ? 0 : quiet + 1;
    endtask

    // Destination-side 3-flop synchronizer and legal-code checker.
    logic [W-1:0] s1 = '0, s2 = '0, s3 = '0;
    always @(posedge dclk) begin
        s1 <= gray0;
        s2 <= s1;
        s3 <= s2;
    end
    always @(negedge dclk) begin
        if (quiet >= 4 && hist.size() >= 4) begin
            bit found;
            found = 1'b0;
            foreach (hist[k]) if (hist[k] == int'(s3)) found = 1'b1;
            check_val("sync_legal", found, 1);
        end
    end

    logic [3:0] up_tab [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                                4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    logic [3:0] dn_bin [7]  = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h0, 4'hF, 4'hE};
    logic [3:0] dn_gray [7] = '{4'h6, 4'h2, 4'h3, 4'h1, 4'h0, 4'h8, 4'h9};

    initial begin
        int toggles;
        logic t_ref;
        model_reset();
        #35;
        check_val("rst_bin", bin0, 0);
        check_val("rst_gray", gray0, 0);
        check_val("rst_tog", tog0, 0);
        check_val("rst_wrap", wrap0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Up count through a full wrap.
        en = 1'b1; dir = 1'b1; clr = 1'b0;
        toggles = 0;
        for (int i = 0; i < 16; i++) begin
            t_ref = tog0;
            tick();
            check_val("up_gray", gray0, up_tab[i]);
            check_val("up_wrap", wrap0, (i == 15));
            if (tog0 != t_ref) toggles++;
        end
        check_val("up_toggles", toggles, 16);

        // To 5, then down through 0.
        for (int i = 0; i < 5; i++) tick();
        check_val("at5", bin0, 5);
        dir = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check_val("dn_bin", bin0, dn_bin[i]);
            check_val("dn_gray", gray0, dn_gray[i]);
            check_val("dn_wrap", wrap0, (i == 5));
        end

        // Saturation at both ends.
        clr = 1'b1; tick(); clr = 1'b0;
        dir = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        t_ref = tog1;
        for (int i = 0; i < 5; i++) tick();
        check_val("sat_hi_bin", bin1, 4'hF);
        check_val("sat_hi_gray", gray1, 4'h8);
        check_val("sat_hi_tog", tog1, t_ref);
        dir = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check_val("sat_lo_bin", bin1, 0);
        check_val("sat_lo_gray", gray1, 0);

        // CLR beats EN and leaves TOG alone.
        clr = 1'b1; tick(); clr = 1'b0;
        dir = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        check_val("at9", bin0, 9);
        t_ref = tog0;
        clr = 1'b1; tick(); clr = 1'b0;
        check_val("clr_bin", bin0, 0);
        check_val("clr_gray", gray0, 0);
        check_val("clr_tog", tog0, t_ref);
        tick();
        check_val("clr_resume", bin0, 1);

        // Asynchronous reset between edges.
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_val("atA", bin0, 4'hA);
        #3 rst_n = 1'b0;
        quiet = 0;
        model_reset();
        #1;
        check_val("arst_bin", bin0, 0);
        check_val("arst_gray", gray0, 0);
        check_val("arst_tog", tog0, 0);
        check_val("arst_wrap", wrap0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        last_clr = 1'b1;
        tick();
        check_val("arst_first", gray0, 1);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            en  = ($urandom % 4) != 0;
            clr = ($urandom % 32) == 0;
            dir = $urandom % 2;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
